// File: rtl/vga_sync_gen_if.sv
// Pin-level bundle between the h/v counter, the sync decoder and the DAC.
// The counter side drives positions and colour; the decoder drives sync, strobes and gated colour.
interface vga_sync_gen_if #(
  parameter int H_WIDTH = 10,
  parameter int V_WIDTH = 10,
  parameter int RGB_W   = 12,
  parameter int FRAME_W = 8
);
  logic [H_WIDTH-1:0] h_count;
  logic [V_WIDTH-1:0] v_count;
  logic [RGB_W-1:0]   rgb_in;

  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [H_WIDTH-1:0] pixel_x;
  logic [V_WIDTH-1:0] pixel_y;
  logic [RGB_W-1:0]   rgb_out;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output h_count, v_count, rgb_in,
    input  hsync, vsync, video_on, pixel_x, pixel_y, rgb_out,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  h_count, v_count, rgb_in,
    output hsync, vsync, video_on, pixel_x, pixel_y, rgb_out,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Decodes raw VGA h/v counts into sync, blanking, coordinates and strobes, delayed
// PIPE_DEPTH cycles to line up with the pixel source, and gates colour to black in blanking.
module vga_sync_gen #(
  parameter int H_WIDTH    = 10,
  parameter int V_WIDTH    = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 47,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 32,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DEPTH = 2,
  parameter int RGB_W      = 12,
  parameter int FRAME_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.slave  bus
);

  // Last legal count on each axis (799 / 524 for standard 640x480).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_WIDTH-1:0] H_ACT_END  = H_WIDTH'(H_ACTIVE);
  localparam logic [H_WIDTH-1:0] H_SYNC_BEG = H_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [H_WIDTH-1:0] H_SYNC_END = H_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_WIDTH-1:0] H_LAST     = H_WIDTH'(H_TOTAL);
  localparam logic [V_WIDTH-1:0] V_ACT_END  = V_WIDTH'(V_ACTIVE);
  localparam logic [V_WIDTH-1:0] V_SYNC_BEG = V_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [V_WIDTH-1:0] V_SYNC_END = V_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_WIDTH-1:0] V_LAST     = V_WIDTH'(V_TOTAL);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  generate
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
      $error("vga_sync_gen: PIPE_DEPTH must be in 1..8");
    end
    if (H_TOTAL >= (1 << H_WIDTH) || V_TOTAL >= (1 << V_WIDTH)) begin : g_bad_width
      $error("vga_sync_gen: timing boundaries do not fit the count widths");
    end
  endgenerate

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               line_start;
    logic               frame_start;
    logic [H_WIDTH-1:0] pixel_x;
    logic [V_WIDTH-1:0] pixel_y;
  } stage_t;

  function automatic stage_t idle_stage();
    stage_t s;
    s             = '0;
    s.hsync       = SYNC_OFF;
    s.vsync       = SYNC_OFF;
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 0: combinational decode of the raw counts
  // ---------------------------------------------------------------------------
  logic   in_range;
  logic   h_act;
  logic   v_act;
  logic   h_in_sync;
  logic   v_in_sync;
  stage_t dec;

  // Out-of-range positions on either axis collapse to plain blanking.
  assign in_range  = (bus.h_count <= H_LAST) && (bus.v_count <= V_LAST);
  assign h_act     = bus.h_count < H_ACT_END;
  assign v_act     = bus.v_count < V_ACT_END;
  assign h_in_sync = (bus.h_count >= H_SYNC_BEG) && (bus.h_count < H_SYNC_END);
  assign v_in_sync = (bus.v_count >= V_SYNC_BEG) && (bus.v_count < V_SYNC_END);

  always_comb begin
    // NOTE: every field gets a value on every path so no latch is inferred.
    dec             = idle_stage();
    dec.video_on    = in_range && h_act && v_act;
    dec.hsync       = (in_range && h_in_sync) ? SYNC_ON : SYNC_OFF;
    dec.vsync       = (in_range && v_in_sync) ? SYNC_ON : SYNC_OFF;
    dec.line_start  = in_range && (bus.h_count == '0);
    dec.frame_start = in_range && (bus.h_count == '0) && (bus.v_count == '0);
    dec.pixel_x     = dec.video_on ? bus.h_count : '0;
    dec.pixel_y     = dec.video_on ? bus.v_count : '0;
  end

  // ---------------------------------------------------------------------------
  // Stages 1..PIPE_DEPTH: plain delay line
  // ---------------------------------------------------------------------------
  stage_t pipe [PIPE_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this is a short control pipeline, not a memory, so every stage is
      // reset to idle levels; that is what keeps outputs quiet while it refills.
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe[i] <= idle_stage();
      end
    end else begin
      // NOTE: non-blocking assignments make each stage take its neighbour's old value.
      pipe[0] <= dec;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Values being loaded into the final stage on this edge.
  logic final_vo;
  logic final_fs;

  generate
    if (PIPE_DEPTH == 1) begin : g_final_from_decode
      assign final_vo = dec.video_on;
      assign final_fs = dec.frame_start;
    end else begin : g_final_from_pipe
      assign final_vo = pipe[PIPE_DEPTH-2].video_on;
      assign final_fs = pipe[PIPE_DEPTH-2].frame_start;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Final-stage colour gate and frame counter
  // ---------------------------------------------------------------------------
  logic [RGB_W-1:0]   rgb_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  // rgb_in already trails its counts by PIPE_DEPTH-1, so it meets final_vo here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= bus.rgb_in & {RGB_W{final_vo}};
    end
  end

  // Updates on the same edge that frame_start reaches the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (final_fs) begin
      frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.hsync       = pipe[PIPE_DEPTH-1].hsync;
  assign bus.vsync       = pipe[PIPE_DEPTH-1].vsync;
  assign bus.video_on    = pipe[PIPE_DEPTH-1].video_on;
  assign bus.line_start  = pipe[PIPE_DEPTH-1].line_start;
  assign bus.frame_start = pipe[PIPE_DEPTH-1].frame_start;
  assign bus.pixel_x     = pipe[PIPE_DEPTH-1].pixel_x;
  assign bus.pixel_y     = pipe[PIPE_DEPTH-1].pixel_y;
  assign bus.rgb_out     = rgb_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
